// File: rtl/bin_pkg.sv
// Shared definitions for the binarized frame reader.
// Holds the state encoding, which is also driven onto condition_led,
// and the default frame geometry.
package bin_pkg;

  localparam int IMG_W = 256;
  localparam int IMG_H = 256;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NBYTE = NPIX / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_FULL    = 2'b10,
    ST_READ    = 2'b11
  } state_e;

endpackage

// File: rtl/bin_frame_ram.sv
// Packed frame store: DEPTH x 8 simple dual-port RAM.
// One synchronous write port and one read port with a 1-cycle registered
// output, written so it infers FPGA block RAM.
//   i_clk            clock
//   i_we/i_waddr/i_wdata  write port
//   i_re/i_raddr     read request; data valid on o_rdata the next cycle
//   o_rdata          registered read data (holds when i_re=0)
module bin_frame_ram #(
  parameter int DEPTH = 8192,
  parameter int AW    = 13
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bin_frame_reader.sv
// Binarized frame sink and byte streamer.
// Captures 1-bit pixels (bin_data[PIX_BIT]) at sequential pixel addresses
// into a packed frame buffer, 8 pixels per byte with the lowest address in
// bit 7. On rd_ctrl in FULL, streams the frame out over out_valid/out_ready.
//   bin_clk, bin_rst_n   clock, async active-low reset
//   int_ctrl             clear: back to IDLE, clears frame_err and counters
//   bin_valid, pixel_address, bin_data   incoming pixel stream
//   rd_ctrl              start readout (sampled in FULL)
//   out_data, out_valid, out_ready       byte stream handshake
//   frame_err            sticky out-of-sequence address flag
//   condition_led        current state (00 IDLE, 01 CAPTURE, 10 FULL, 11 READ)
module bin_frame_reader
  import bin_pkg::*;
#(
  parameter int IMG_W   = bin_pkg::IMG_W,
  parameter int IMG_H   = bin_pkg::IMG_H,
  parameter int ADDR_W  = 16,
  parameter int PIX_BIT = 7
) (
  input  logic              bin_clk,
  input  logic              bin_rst_n,
  input  logic              int_ctrl,
  input  logic              bin_valid,
  input  logic [ADDR_W-1:0] pixel_address,
  input  logic [7:0]        bin_data,
  input  logic              rd_ctrl,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic [1:0]        condition_led
);

  localparam int FRAME_PIX   = IMG_W * IMG_H;
  localparam int FRAME_BYTES = FRAME_PIX / 8;
  localparam int BA_W        = $clog2(FRAME_BYTES);

  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(FRAME_PIX - 1);
  localparam logic [BA_W-1:0]   LAST_BYTE = BA_W'(FRAME_BYTES - 1);
  localparam logic [BA_W:0]     END_FETCH = (BA_W + 1)'(FRAME_BYTES);

  state_e r_state;
  state_e w_state_nxt;

  logic [7:0]        r_acc;
  logic [ADDR_W-1:0] r_exp_addr;
  logic              r_frame_err;
  logic [BA_W:0]     r_fetch_addr;
  logic [BA_W-1:0]   r_byte_cnt;
  logic              r_pending;
  logic              r_out_valid;
  logic [7:0]        r_out_data;
  logic              r_skid_valid;
  logic [7:0]        r_skid_data;

  logic       w_take_start;
  logic       w_take_cap;
  logic       w_take;
  logic       w_addr_err;
  logic       w_last_pix;
  logic       w_we;
  logic [7:0] w_acc_next;
  logic       w_rd_start;
  logic       w_pop;
  logic       w_last_pop;
  logic [1:0] w_occ;
  logic       w_room;
  logic       w_issue;
  logic [7:0] w_ram_rdata;
  logic       w_unused;

  // Capture side
  assign w_acc_next   = {r_acc[6:0], bin_data[PIX_BIT]};
  assign w_take_start = bin_valid && (pixel_address == '0) &&
                        ((r_state == ST_IDLE) || ((r_state == ST_FULL) && !rd_ctrl));
  assign w_take_cap   = (r_state == ST_CAPTURE) && bin_valid && (pixel_address == r_exp_addr);
  assign w_take       = w_take_start || w_take_cap;
  assign w_addr_err   = (r_state == ST_CAPTURE) && bin_valid && (pixel_address != r_exp_addr);
  assign w_last_pix   = w_take_cap && (pixel_address == LAST_PIX);
  assign w_we         = w_take && !int_ctrl && (pixel_address[2:0] == 3'b111);

  // Readout side. Occupancy counts the output register, the skid register
  // and a RAM read in flight; a new read is issued only if that total,
  // after this cycle's handshake, stays within the two holding registers.
  assign w_rd_start = (r_state == ST_FULL) && rd_ctrl;
  assign w_pop      = r_out_valid && out_ready;
  assign w_last_pop = (r_state == ST_READ) && w_pop && (r_byte_cnt == LAST_BYTE);
  assign w_occ      = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_pending};
  assign w_room     = (w_occ - {1'b0, w_pop}) <= 2'd1;
  assign w_issue    = (r_state == ST_READ) && (r_fetch_addr < END_FETCH) && w_room && !w_last_pop;

  assign w_unused = ^{bin_data, pixel_address};

  bin_frame_ram #(
    .DEPTH (FRAME_BYTES),
    .AW    (BA_W)
  ) u_ram (
    .i_clk   (bin_clk),
    .i_we    (w_we),
    .i_waddr (pixel_address[BA_W+2:3]),
    .i_wdata (w_acc_next),
    .i_re    (w_issue),
    .i_raddr (r_fetch_addr[BA_W-1:0]),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge bin_clk or negedge bin_rst_n) begin
    if (!bin_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (int_ctrl) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:    if (w_take_start) w_state_nxt = ST_CAPTURE;
        ST_CAPTURE: if (w_last_pix)   w_state_nxt = ST_FULL;
        ST_FULL: begin
          if (rd_ctrl) begin
            w_state_nxt = ST_READ;
          end else if (w_take_start) begin
            w_state_nxt = ST_CAPTURE;
          end
        end
        ST_READ:    if (w_last_pop)   w_state_nxt = ST_FULL;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge bin_clk or negedge bin_rst_n) begin
    if (!bin_rst_n) begin
      r_acc        <= '0;
      r_exp_addr   <= '0;
      r_frame_err  <= 1'b0;
      r_fetch_addr <= '0;
      r_byte_cnt   <= '0;
      r_pending    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (int_ctrl) begin
      r_acc        <= '0;
      r_exp_addr   <= '0;
      r_frame_err  <= 1'b0;
      r_fetch_addr <= '0;
      r_byte_cnt   <= '0;
      r_pending    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else begin
      if (w_take) begin
        r_acc      <= w_acc_next;
        r_exp_addr <= w_take_start ? ADDR_W'(1) : r_exp_addr + 1'b1;
      end
      if (w_addr_err) begin
        r_frame_err <= 1'b1;
      end

      if (w_rd_start) begin
        r_fetch_addr <= '0;
        r_byte_cnt   <= '0;
        r_pending    <= 1'b0;
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (r_state == ST_READ) begin
        r_pending <= w_issue;
        if (w_issue) begin
          r_fetch_addr <= r_fetch_addr + 1'b1;
        end
        if (w_pop) begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
        if (w_last_pop) begin
          r_out_valid  <= 1'b0;
          r_skid_valid <= 1'b0;
        end else if (!r_out_valid || w_pop) begin
          // Output slot frees up: skid byte is older than the RAM byte.
          if (r_skid_valid) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= r_skid_data;
            r_skid_valid <= r_pending;
            r_skid_data  <= w_ram_rdata;
          end else begin
            r_out_valid <= r_pending;
            if (r_pending) begin
              r_out_data <= w_ram_rdata;
            end
          end
        end else if (r_pending) begin
          // Stalled with a read landing: park it in the skid register.
          r_skid_valid <= 1'b1;
          r_skid_data  <= w_ram_rdata;
        end
      end
    end
  end

  assign out_data      = r_out_data;
  assign out_valid     = r_out_valid;
  assign frame_err     = r_frame_err;
  assign condition_led = r_state;

endmodule

// File: tb/tb_bin_frame_reader.sv
module tb_bin_frame_reader;

  localparam int IMG_W   = 32;
  localparam int IMG_H   = 16;
  localparam int ADDR_W  = 9;
  localparam int PIX_BIT = 7;
  localparam int NPIX    = IMG_W * IMG_H;
  localparam int NBYTE   = NPIX / 8;

  logic              bin_clk;
  logic              bin_rst_n;
  logic              int_ctrl;
  logic              bin_valid;
  logic [ADDR_W-1:0] pixel_address;
  logic [7:0]        bin_data;
  logic              rd_ctrl;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic [1:0]        condition_led;

  bin_frame_reader #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .ADDR_W  (ADDR_W),
    .PIX_BIT (PIX_BIT)
  ) dut (
    .bin_clk       (bin_clk),
    .bin_rst_n     (bin_rst_n),
    .int_ctrl      (int_ctrl),
    .bin_valid     (bin_valid),
    .pixel_address (pixel_address),
    .bin_data      (bin_data),
    .rd_ctrl       (rd_ctrl),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .frame_err     (frame_err),
    .condition_led (condition_led)
  );

  initial bin_clk = 1'b0;
  always #5 bin_clk = ~bin_clk;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;
  int t_first = 0;
  int t_last = 0;
  int cyc = 0;
  logic [7:0] exp_q [$];

  always @(posedge bin_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Kind 0: 0xFF on even pixels, 0x00 on odd -> every byte 0xAA.
  // Kind 1: byte b holds (37*b+5) mod 256, so ordering errors show up.
  function automatic logic [7:0] exp_byte(input int kind, input int b);
    if (kind == 0) return 8'hAA;
    return 8'((b * 37 + 5) % 256);
  endfunction

  function automatic logic [7:0] pix(input int kind, input int a);
    logic [7:0] v;
    v = exp_byte(kind, a / 8);
    return v[7 - (a % 8)] ? 8'hFF : 8'h00;
  endfunction

  // Monitor: pops the scoreboard on every handshake, checks stall stability.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge bin_clk);
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected no byte", out_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_byte", 32'(out_data), 32'(e));
        end
        if (rd_count == 0) t_first = cyc;
        t_last = cyc;
        rd_count++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready && !int_ctrl;
      prev_data  = out_data;
    end
  end

  task automatic send(input int a, input int kind);
    bin_valid     = 1'b1;
    pixel_address = ADDR_W'(a);
    bin_data      = pix(kind, a);
    @(posedge bin_clk); #1;
    bin_valid = 1'b0;
  endtask

  task automatic capture(input int kind, input bit gap, input bit err);
    int c;
    c = 0;
    for (int p = 0; p < NPIX; p++) begin
      if (err && p == 101) begin
        send(105, kind);
        check("frame_err_set", 32'(frame_err), 32'd1);
      end
      if (gap && (c % 3 == 2)) begin
        bin_valid = 1'b0;
        @(posedge bin_clk); #1;
        c++;
      end
      if (p == 1 || p == NPIX - 1) check("led_capture", 32'(condition_led), 32'h1);
      send(p, kind);
      c++;
    end
    check("led_full", 32'(condition_led), 32'h2);
    check("frame_err_after", 32'(frame_err), err ? 32'd1 : 32'd0);
  endtask

  // stop_at < 0 reads the whole frame; otherwise returns once stop_at bytes
  // have been accepted, with out_ready still high.
  task automatic do_read(input int kind, input bit bp, input bit collide, input int stop_at);
    int n;
    int target;
    int limit;
    for (int b = 0; b < NBYTE; b++) exp_q.push_back(exp_byte(kind, b));
    rd_count  = 0;
    out_ready = 1'b1;
    rd_ctrl   = 1'b1;
    if (collide) begin
      bin_valid     = 1'b1;
      pixel_address = '0;
      bin_data      = 8'h00;
    end
    @(posedge bin_clk); #1;
    rd_ctrl   = 1'b0;
    bin_valid = 1'b0;
    check("led_read", 32'(condition_led), 32'h3);
    target = (stop_at >= 0) ? stop_at : NBYTE;
    limit  = 8 * NBYTE + 50;
    n = 0;
    while (rd_count < target && n < limit) begin
      if (bp) out_ready = ((n % 4) == 0) || ((n % 4) == 3);
      @(posedge bin_clk); #1;
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout: got %0d bytes expected %0d", rd_count, target);
    end
    if (stop_at < 0) begin
      out_ready = 1'b1;
      check("rd_count", 32'(rd_count), 32'(NBYTE));
      check("led_after_read", 32'(condition_led), 32'h2);
      check("valid_after_read", 32'(out_valid), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      if (!bp) check("no_bubble", 32'(t_last - t_first), 32'(NBYTE - 1));
    end
  endtask

  task automatic pulse_clear();
    int_ctrl = 1'b1;
    @(posedge bin_clk); #1;
    int_ctrl = 1'b0;
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_led", 32'(condition_led), 32'h0);
    check("clr_err", 32'(frame_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bin_rst_n     = 1'b0;
    int_ctrl      = 1'b0;
    bin_valid     = 1'b0;
    pixel_address = '0;
    bin_data      = '0;
    rd_ctrl       = 1'b0;
    out_ready     = 1'b0;
    repeat (3) @(posedge bin_clk);
    #1 bin_rst_n = 1'b1;
    @(posedge bin_clk); #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_led", 32'(condition_led), 32'h0);
    check("rst_err", 32'(frame_err), 32'd0);

    // Nonzero address in IDLE is ignored.
    send(5, 0);
    check("idle_ignore", 32'(condition_led), 32'h0);

    // Full capture, sustained readout, then re-read of the same frame.
    capture(0, 1'b0, 1'b0);
    do_read(0, 1'b0, 1'b0, -1);
    do_read(0, 1'b0, 1'b0, -1);

    // Backpressure 1,0,0,1.
    capture(1, 1'b0, 1'b0);
    do_read(1, 1'b1, 1'b0, -1);

    // Gapped capture; rd_ctrl collides with a new address-0 pixel.
    capture(1, 1'b1, 1'b0);
    do_read(1, 1'b0, 1'b1, -1);

    // Address jump 100 -> 105; the stray pixel is dropped.
    capture(1, 1'b0, 1'b1);
    do_read(1, 1'b0, 1'b0, -1);
    check("err_sticky", 32'(frame_err), 32'd1);
    pulse_clear();

    // Clear in the middle of a readout, then a fresh frame.
    capture(1, 1'b0, 1'b0);
    do_read(1, 1'b0, 1'b0, 20);
    pulse_clear();
    exp_q.delete();
    repeat (3) @(posedge bin_clk);
    #1;
    check("clr_idle_hold", 32'(out_valid), 32'd0);
    capture(0, 1'b0, 1'b0);
    do_read(0, 1'b0, 1'b0, -1);

    repeat (5) @(posedge bin_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
